// File: rtl/lib_sdiv_34d8.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock, signs applied at the end.
// Latency: out_valid rises after the accept edge + Nx + 1, fixed for dz/ovf cases too.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no overlap between operations.
module lib_sdiv_34d8 #(
    parameter int Na = 8,
    parameter int Nx = 34,
    parameter int Nc = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [Nx-1:0] x,
    input  logic [Na-1:0] a,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Nx-1:0] q,
    output logic [Na-1:0] r,
    output logic          dz,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [Nc-1:0] LAST  = Nc'(Nx - 1);
    localparam logic [Nx-1:0] X_MIN = {1'b1, {(Nx-1){1'b0}}};

    state_t        state_q, state_d;
    logic [Nc-1:0] cnt_q, cnt_d;
    logic [Nx-1:0] dvd_q, dvd_d;
    logic [Na:0]   rem_q, rem_d;
    logic [Na-1:0] mag_a_q, mag_a_d;
    logic          sx_q, sx_d, sa_q, sa_d;
    logic          dzp_q, dzp_d, ovfp_q, ovfp_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [Nx-1:0] q_q, q_d;
    logic [Na-1:0] r_q, r_d;
    logic          dz_q, dz_d, ovf_q, ovf_d;

    logic [Na+1:0] rem_shift;
    logic [Na+1:0] diff;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        mag_a_d     = mag_a_q;
        sx_d        = sx_q;
        sa_d        = sa_q;
        dzp_d       = dzp_q;
        ovfp_d      = ovfp_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;

        // dvd_q holds the dividend magnitude; quotient bits fill in from the LSB as it shifts out
        rem_shift = {rem_q, dvd_q[Nx-1]};
        diff      = rem_shift - {2'b00, mag_a_q};

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_ready_q && in_valid) begin
                    in_ready_d = 1'b0;
                    dvd_d      = x[Nx-1] ? -x : x;
                    mag_a_d    = a[Na-1] ? -a : a;
                    sx_d       = x[Nx-1];
                    sa_d       = a[Na-1];
                    dzp_d      = (a == '0);
                    ovfp_d     = (x == X_MIN) && (a == '1);
                    cnt_d      = '0;
                    rem_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                rem_d = diff[Na+1] ? rem_shift[Na:0] : diff[Na:0];
                dvd_d = {dvd_q[Nx-2:0], ~diff[Na+1]};
                cnt_d = cnt_q + Nc'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_valid_d = 1'b1;
                state_d     = DONE;
                dz_d        = dzp_q;
                ovf_d       = ovfp_q && !dzp_q;
                if (dzp_q) begin
                    q_d = '0;
                    r_d = '0;
                end else if (ovfp_q) begin
                    q_d = X_MIN;
                    r_d = '0;
                end else begin
                    q_d = (sx_q ^ sa_q) ? -dvd_q : dvd_q;
                    r_d = sx_q ? -rem_q[Na-1:0] : rem_q[Na-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            mag_a_q     <= '0;
            sx_q        <= 1'b0;
            sa_q        <= 1'b0;
            dzp_q       <= 1'b0;
            ovfp_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            mag_a_q     <= mag_a_d;
            sx_q        <= sx_d;
            sa_q        <= sa_d;
            dzp_q       <= dzp_d;
            ovfp_q      <= ovfp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/lib_sdiv_34d8.md
Name: lib_sdiv_34d8

Overview:
- Sequential signed divider: the inverse of the library's 8x26 signed multiplier.
- Divides an Nx-bit two's-complement dividend by an Na-bit two's-complement divisor, one quotient bit per clock (restoring, magnitude domain), then applies signs.
- Valid/ready handshake on both sides; used wherever a scaled product must be brought back to its operand scale.

Parameters:
- Na, 8: divisor width (signed)
- Nx, 34: dividend and quotient width (signed)
- Nc, 6: iteration counter width; must satisfy 2^Nc > Nx

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block idle, can accept operands
- x  in  Nx  dividend, signed
- a  in  Na  divisor, signed
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- q  out  Nx  quotient, signed
- r  out  Na  remainder, signed
- dz  out  1  divide-by-zero flag for current result
- ovf  out  1  quotient-overflow flag for current result

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: in_ready=0, out_valid=0, q=0, r=0, dz=0, ovf=0, state=IDLE.
- After rst deasserts, in_ready rises on the first clk edge. All control and output regs are registered.
- States:
  - IDLE: in_ready=1.
  - RUN: Nx cycles.
  - FIX: 1 cycle.
  - DONE: out_valid=1 until consumed.
- Accept: at a clk edge with in_valid & in_ready (edge E0), the block:
  - latches |x| as Nx-bit unsigned (|-2^(Nx-1)| = 2^(Nx-1) is exact) and |a| as Na-bit unsigned;
  - latches sign bits x[Nx-1] and a[Na-1], plus flags dz=(a==0) and ovf=(x==-2^(Nx-1) & a==-1);
  - clears the counter, drops in_ready and enters RUN.
- Operands are sampled only at E0; later changes on x/a/in_valid have no effect until the next IDLE.
- RUN: each edge shifts one dividend magnitude bit (MSB first) into the partial remainder (Na+1 bits). The block subtracts |a|; if the result is non-negative it keeps the difference and shifts in quotient bit 1, otherwise it keeps the value and shifts in 0. After Nx edges it enters FIX.
- FIX (one edge) computes the results:
  - Quotient: magnitude negated if x sign ^ a sign. The result is truncated toward zero.
  - Remainder: negated if x sign (remainder sign follows dividend); |r| < |a|.
  - Divide-by-zero: dz=1 forces q=0, r=0, ovf=0.
  - Overflow: ovf=1 gives q=-2^(Nx-1) (two's-complement wrap) and r=0.
  - Registers q, r, dz, ovf, asserts out_valid and enters DONE.
- Latency: out_valid rises after edge E0+Nx+1 (edge 35 after accept with default Nx=34). The latency is fixed and identical for dz/ovf cases.
- DONE: q/r/dz/ovf are held stable while out_valid=1.
  - At an edge with out_ready=1, out_valid falls and the state returns to IDLE; in_ready rises after that same edge.
  - No same-cycle re-accept. Minimum issue interval is Nx+3 cycles.
- out_ready is ignored when out_valid=0. in_valid is ignored outside IDLE.
- q/r keep their last values after out_valid falls, until the next FIX.
- rst asserted mid-RUN/FIX/DONE: the in-flight operation is discarded immediately and all outputs return to reset values. No result is emitted for the aborted operation.
- Width rules: the partial remainder is Na+1 bits to hold 2*|a|-1. Remainder magnitude ≤ 2^(Na-1)-1 except for a=-128, where it is ≤ 127, so r fits Na signed bits in all cases.

Test Plan:
1. x=1000, a=7, out_ready=1 → out_valid after edge E0+35; q=142, r=6, dz=0, ovf=0; in_ready high one edge later.
2. Sign matrix:
   - x=-1000, a=7 → q=-142, r=-6
   - x=1000, a=-7 → q=-142, r=6
   - x=-1000, a=-7 → q=142, r=-6
   - x=5, a=-128 → q=0, r=5
3. Flag cases:
   - x=12345, a=0 → dz=1, q=0, r=0, same latency.
   - x=-2^33, a=-1 → ovf=1, q=-2^33 (0x2_0000_0000), r=0.
   - x=-2^33, a=1 → ovf=0, q=-2^33, r=0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid while driving in_valid=1 with new x/a → q/r stable, in_ready=0, new operands not accepted. Raise out_ready → one transfer, then accept next operands.
5. Reset mid-operation: assert rst asynchronously 10 cycles into RUN → out_valid=0 and in_ready=0 immediately. After release, in_ready=1 next edge; a fresh x=100, a=-3 yields q=-33, r=1 with no stale result emitted.
6. Randomised back-to-back stream (≥1000 ops, random out_ready stalls) against a truncating signed-division model → every q/r/dz/ovf matches; q*a+r==x whenever dz=0 and ovf=0.
